// File: rtl/pieo_sched_pkg.sv
// Shared PIEO scheduler definitions: geometry, element field layout and
// pack/unpack helpers used by the enqueue tracker, the PIEO and post-dequeue.
package pieo_sched_pkg;

   localparam int NUM_QUEUES = 3;
   localparam int ID_LOG     = $clog2(NUM_QUEUES);
   localparam int RANK_LOG   = 1;
   localparam int TIME_LOG   = 1;
   localparam int ELEM_W     = ID_LOG + RANK_LOG + TIME_LOG;

   localparam int ID_LSB   = 0;
   localparam int RANK_LSB = ID_LOG;
   localparam int TIME_LSB = ID_LOG + RANK_LOG;

   typedef logic [ID_LOG-1:0]   id_t;
   typedef logic [RANK_LOG-1:0] rank_t;
   typedef logic [TIME_LOG-1:0] time_t;
   typedef logic [ELEM_W-1:0]   elem_t;
   typedef logic [ID_LOG:0]     count_t;

   function automatic elem_t elem_pack(time_t t, rank_t r, id_t id);
      elem_t e;
      e = '0;
      e[ID_LSB   +: ID_LOG]   = id;
      e[RANK_LSB +: RANK_LOG] = r;
      e[TIME_LSB +: TIME_LOG] = t;
      return e;
   endfunction

   function automatic id_t elem_id(elem_t e);
      return e[ID_LSB +: ID_LOG];
   endfunction

   function automatic rank_t elem_rank(elem_t e);
      return e[RANK_LSB +: RANK_LOG];
   endfunction

   function automatic time_t elem_time(elem_t e);
      return e[TIME_LSB +: TIME_LOG];
   endfunction

   function automatic count_t popcount(logic [NUM_QUEUES-1:0] m);
      count_t c;
      c = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         c = c + count_t'(m[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/pieo_enq_fifo_tracker_if.sv
// Bundle between the enqueue tracker and its environment (FIFOs, shaper,
// post-dequeue stage and the PIEO enqueue port).
interface pieo_enq_fifo_tracker_if;
   import pieo_sched_pkg::*;

   logic                           en_in;
   logic [NUM_QUEUES-1:0]          fifo_tvalid;
   logic [NUM_QUEUES-1:0]          tb_fifo_eligible;
   logic [NUM_QUEUES-1:0]          post_deq_end;
   logic [NUM_QUEUES*RANK_LOG-1:0] fifo_rank;
   logic                           enq_valid;
   logic                           enq_ready;
   logic [ELEM_W-1:0]              enq_element;
   logic [NUM_QUEUES-1:0]          queued_mask;
   logic [ID_LOG:0]                queued_count;
   logic                           protocol_err;

   modport master (
      input  en_in, fifo_tvalid, tb_fifo_eligible, post_deq_end, fifo_rank, enq_ready,
      output enq_valid, enq_element, queued_mask, queued_count, protocol_err
   );

   modport slave (
      output en_in, fifo_tvalid, tb_fifo_eligible, post_deq_end, fifo_rank, enq_ready,
      input  enq_valid, enq_element, queued_mask, queued_count, protocol_err
   );

endinterface

// File: rtl/pieo_enq_fifo_tracker_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping correctly for non-power-of-two N.
module rr_arbiter #(
   parameter int N = 3,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant_id,
   output logic         grant_valid
);

   logic [N-1:0] rot_req;
   logic [W-1:0] rot_id [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] sum;
      assign sum          = {1'b0, ptr} + (W+1)'(gi);
      assign rot_id[gi]   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
      assign rot_req[gi]  = req[rot_id[gi]];
   end

   // Scan from the far end so the slot nearest ptr overwrites last.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_req[k]) begin
            grant_valid = 1'b1;
            grant_id    = rot_id[k];
         end
      end
   end

endmodule

// File: rtl/pieo_enq_fifo_tracker.sv
// Enqueue-side flow tracker: issues one {time, rank, id} element per
// non-empty, eligible, non-resident queue and tracks PIEO residency.
module pieo_enq_fifo_tracker
   import pieo_sched_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   pieo_enq_fifo_tracker_if.master     bus
);

   logic                  enq_valid_q, enq_valid_d;
   elem_t                 elem_q, elem_d;
   logic [NUM_QUEUES-1:0] mask_q, mask_d;
   count_t                count_q, count_d;
   logic                  err_q, err_d;
   id_t                   rr_q, rr_d;
   time_t                 ts_q;

   logic [NUM_QUEUES-1:0] cand;
   logic [NUM_QUEUES-1:0] acc_hit;
   logic [NUM_QUEUES-1:0] err_hit;
   rank_t                 rank_arr [NUM_QUEUES];
   id_t                   held_id;
   id_t                   grant_id;
   logic                  grant_valid;
   logic                  accept;
   logic                  load;

   assign held_id = elem_id(elem_q);
   assign accept  = enq_valid_q & bus.enq_ready;

   // The held element is excluded so the accepting edge picks a different queue.
   for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
      logic is_held;
      assign is_held      = enq_valid_q && (held_id == id_t'(gi));
      assign rank_arr[gi] = bus.fifo_rank[gi*RANK_LOG +: RANK_LOG];
      assign cand[gi]     = bus.fifo_tvalid[gi] & bus.tb_fifo_eligible[gi]
                            & ~mask_q[gi] & ~is_held;
      assign acc_hit[gi]  = accept & is_held;
      assign mask_d[gi]   = acc_hit[gi] | (mask_q[gi] & ~bus.post_deq_end[gi]);
      assign err_hit[gi]  = bus.post_deq_end[gi] & (~mask_q[gi] | acc_hit[gi]);
   end

   rr_arbiter #(.N(NUM_QUEUES)) u_arb (
      .req         (cand),
      .ptr         (rr_q),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   assign load = bus.en_in & grant_valid & (~enq_valid_q | accept);

   always_comb begin
      enq_valid_d = enq_valid_q;
      elem_d      = elem_q;
      rr_d        = rr_q;
      if (load) begin
         enq_valid_d = 1'b1;
         elem_d      = elem_pack(ts_q, rank_arr[grant_id], grant_id);
      end else if (accept) begin
         enq_valid_d = 1'b0;
      end
      if (accept) begin
         rr_d = (held_id == id_t'(NUM_QUEUES - 1)) ? '0 : held_id + id_t'(1);
      end
      count_d = popcount(mask_d);
      err_d   = err_q | (|err_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enq_valid_q <= 1'b0;
         elem_q      <= '0;
         mask_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         rr_q        <= '0;
         ts_q        <= '0;
      end else begin
         enq_valid_q <= enq_valid_d;
         elem_q      <= elem_d;
         mask_q      <= mask_d;
         count_q     <= count_d;
         err_q       <= err_d;
         rr_q        <= rr_d;
         ts_q        <= ts_q + time_t'(1);
      end
   end

   assign bus.enq_valid    = enq_valid_q;
   assign bus.enq_element  = elem_q;
   assign bus.queued_mask  = mask_q;
   assign bus.queued_count = count_q;
   assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_pieo_enq_fifo_tracker.sv
// Scoreboard bench for the enqueue tracker: directed scenarios then random traffic
// against a queue-level reference model.
module tb_pieo_enq_fifo_tracker;
   import pieo_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pieo_enq_fifo_tracker_if bus();

   pieo_enq_fifo_tracker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit       v;
      bit [3:0] e;
      bit [2:0] m;
      int       cnt;
      bit       err;
   } st_t;

   st_t      exp_st[$];
   bit [3:0] exp_acc[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state, at the level of "which queues are resident".
   bit m_v;
   int m_id, m_rank, m_time;
   bit m_res[3];
   int m_rr, m_ts;
   bit m_err;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [3:0] mk_elem(int t, int r, int id);
      return 4'((t << 3) | (r << 2) | id);
   endfunction

   task automatic drive(input bit r, input bit en, input bit [2:0] tv, input bit [2:0] el,
                        input bit [2:0] pde, input bit [2:0] rk, input bit rdy);
      bit   acc;
      bit   found;
      int   win;
      int   q;
      st_t  s;
      @(posedge clk);
      #2;
      rst                  = r;
      bus.en_in            = en;
      bus.fifo_tvalid      = tv;
      bus.tb_fifo_eligible = el;
      bus.post_deq_end     = pde;
      bus.fifo_rank        = rk;
      bus.enq_ready        = rdy;
      if (r) begin
         m_v = 0; m_id = 0; m_rank = 0; m_time = 0;
         for (int i = 0; i < 3; i++) m_res[i] = 0;
         m_rr = 0; m_ts = 0; m_err = 0;
      end else begin
         acc = m_v && rdy;
         if (acc) exp_acc.push_back(mk_elem(m_time, m_rank, m_id));
         found = 0;
         win   = 0;
         for (int k = 0; k < 3; k++) begin
            q = (m_rr + k) % 3;
            if (!found && tv[q] && el[q] && !m_res[q] && !(m_v && q == m_id)) begin
               found = 1;
               win   = q;
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (pde[i] && (!m_res[i] || (acc && m_id == i))) m_err = 1;
            if (acc && m_id == i) m_res[i] = 1;
            else if (pde[i]) m_res[i] = 0;
         end
         if (acc) m_rr = (m_id + 1) % 3;
         if (en && found && (!m_v || acc)) begin
            m_v    = 1;
            m_id   = win;
            m_rank = int'(rk[win]);
            m_time = m_ts;
         end else if (acc) begin
            m_v = 0;
         end
         m_ts = (m_ts + 1) % 2;
      end
      s.v   = m_v;
      s.e   = mk_elem(m_time, m_rank, m_id);
      s.m   = {m_res[2], m_res[1], m_res[0]};
      s.cnt = int'(m_res[0]) + int'(m_res[1]) + int'(m_res[2]);
      s.err = m_err;
      exp_st.push_back(s);
   endtask

   // State monitor: one expected snapshot per clock edge.
   initial begin
      st_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_st.size() > 0) begin
            x = exp_st.pop_front();
            check("enq_valid", int'(bus.enq_valid), int'(x.v));
            check("enq_element", int'(bus.enq_element), int'(x.e));
            check("queued_mask", int'(bus.queued_mask), int'(x.m));
            check("queued_count", int'(bus.queued_count), x.cnt);
            check("protocol_err", int'(bus.protocol_err), int'(x.err));
         end
      end
   end

   // Accept monitor: every handshake must match the next expected element.
   initial begin
      bit [3:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.enq_valid === 1'b1 && bus.enq_ready === 1'b1) begin
            if (exp_acc.size() == 0) begin
               check("unexpected_accept", int'(bus.enq_element), -1);
            end else begin
               e = exp_acc.pop_front();
               check("accepted_element", int'(bus.enq_element), int'(e));
            end
         end
      end
   end

   initial begin
      bit [2:0] pde;
      bus.en_in = 0; bus.fifo_tvalid = 0; bus.tb_fifo_eligible = 0;
      bus.post_deq_end = 0; bus.fifo_rank = 0; bus.enq_ready = 0;
      m_v = 0; m_id = 0; m_rank = 0; m_time = 0; m_rr = 0; m_ts = 0; m_err = 0;
      for (int i = 0; i < 3; i++) m_res[i] = 0;

      repeat (2) drive(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
      // Single flow on q1
      repeat (3) drive(0, 1, 3'b010, 3'b010, 3'b000, 3'b010, 1);
      // Stall on q0 while its tvalid drops
      drive(0, 1, 3'b001, 3'b001, 3'b000, 3'b001, 0);
      repeat (5) drive(0, 1, 3'b000, 3'b001, 3'b000, 3'b001, 0);
      repeat (2) drive(0, 1, 3'b000, 3'b001, 3'b000, 3'b001, 1);
      // Round-robin over all queues
      drive(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
      repeat (5) drive(0, 1, 3'b111, 3'b111, 3'b000, 3'b101, 1);
      // Return of q2 and re-enqueue
      drive(0, 1, 3'b111, 3'b111, 3'b100, 3'b101, 1);
      repeat (3) drive(0, 1, 3'b111, 3'b111, 3'b000, 3'b101, 1);
      // Gating by eligibility, then by en_in
      drive(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
      repeat (2) drive(0, 1, 3'b010, 3'b000, 3'b000, 3'b010, 1);
      repeat (2) drive(0, 0, 3'b010, 3'b010, 3'b000, 3'b010, 1);
      repeat (2) drive(0, 1, 3'b010, 3'b010, 3'b000, 3'b010, 1);
      // Spurious post_deq_end on a non-resident queue, then clear by reset
      drive(0, 1, 3'b000, 3'b000, 3'b001, 3'b000, 1);
      repeat (2) drive(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      drive(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);

      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (m_res[i]) pde[i] = ($urandom_range(0, 3) == 0);
            else          pde[i] = ($urandom_range(0, 63) == 0);
         end
         drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
               3'($urandom_range(0, 7) | $urandom_range(0, 7)),
               3'($urandom_range(0, 7) | $urandom_range(0, 7)),
               pde, 3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
      end

      drive(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
      repeat (3) @(posedge clk);
      #3;
      check("acc_drained", exp_acc.size(), 0);
      check("state_drained", exp_st.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
